// File: rtl/riscv_pu_mem_load_store_unit.sv
// MEM stage load/store unit: turns EX results into single AXI-Lite read or write transactions
// and returns lane-aligned, extended load data; non-memory results pass through in one cycle.
module riscv_pu_mem_load_store_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [2:0]            i_width,
    input  logic [DATA_WIDTH-1:0] i_alu_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_misaligned,
    output logic                  o_bus_error,
    output logic [ADDR_WIDTH-1:0] o_araddr,
    output logic                  o_arvalid,
    input  logic                  i_arready,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_rresp,
    input  logic                  i_rvalid,
    output logic                  o_rready,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [7:0]            o_wstrb,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    input  logic [1:0]            i_bresp,
    input  logic                  i_bvalid,
    output logic                  o_bready
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, data_q, data_d;
    logic [7:0]            wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic [2:0]            off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  sign_q, sign_d, mis_q, mis_d, berr_q, berr_d;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'd1:    return off[0];
            2'd2:    return |off[1:0];
            2'd3:    return |off;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [7:0] store_strb(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    // Shift the addressed lane down to bit 0, then extend from the top bit of the access size.
    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] raw,
                                                          input logic [2:0] off,
                                                          input logic [1:0] size,
                                                          input logic sgn);
        logic [DATA_WIDTH-1:0] s;
        s = raw >> {off, 3'b000};
        case (size)
            2'd0:    return {{56{sgn & s[7]}}, s[7:0]};
            2'd1:    return {{48{sgn & s[15]}}, s[15:0]};
            2'd2:    return {{32{sgn & s[31]}}, s[31:0]};
            default: return s;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        off_d     = off_q;
        size_d    = size_q;
        sign_d    = sign_q;
        data_d    = data_q;
        mis_d     = mis_q;
        berr_d    = berr_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    off_d  = i_alu_data[2:0];
                    size_d = i_width[1:0];
                    sign_d = i_width[2];
                    if (!(i_read || i_write)) begin
                        data_d  = i_alu_data;
                        mis_d   = 1'b0;
                        berr_d  = 1'b0;
                        state_d = DONE;
                    end else if (is_misaligned(i_width[1:0], i_alu_data[2:0])) begin
                        data_d  = '0;
                        mis_d   = 1'b1;
                        berr_d  = 1'b0;
                        state_d = DONE;
                    end else if (i_read) begin
                        araddr_d = {i_alu_data[ADDR_WIDTH-1:3], 3'b000};
                        state_d  = RD_ADDR;
                    end else begin
                        awaddr_d  = {i_alu_data[ADDR_WIDTH-1:3], 3'b000};
                        wdata_d   = (i_rs2_data & size_mask(i_width[1:0])) << {i_alu_data[2:0], 3'b000};
                        wstrb_d   = store_strb(i_width[1:0], i_alu_data[2:0]);
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end
                end
            end
            RD_ADDR: begin
                if (i_arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (i_rvalid) begin
                    data_d  = load_extend(i_rdata, off_q, size_q, sign_q);
                    mis_d   = 1'b0;
                    berr_d  = (i_rresp != 2'b00);
                    state_d = DONE;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; move on once both have handshaken.
                awvalid_d = awvalid_q & ~i_awready;
                wvalid_d  = wvalid_q & ~i_wready;
                if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (i_bvalid) begin
                    data_d  = '0;
                    mis_d   = 1'b0;
                    berr_d  = (i_bresp != 2'b00);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            araddr_q  <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            off_q     <= '0;
            size_q    <= '0;
            sign_q    <= 1'b0;
            data_q    <= '0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            off_q     <= off_d;
            size_q    <= size_d;
            sign_q    <= sign_d;
            data_q    <= data_d;
            mis_q     <= mis_d;
            berr_q    <= berr_d;
        end
    end

    assign o_ready      = (state_q == IDLE);
    assign o_valid      = (state_q == DONE);
    assign o_data       = data_q;
    assign o_misaligned = mis_q;
    assign o_bus_error  = berr_q;
    assign o_araddr     = araddr_q;
    assign o_arvalid    = (state_q == RD_ADDR);
    assign o_rready     = (state_q == RD_DATA);
    assign o_awaddr     = awaddr_q;
    assign o_awvalid    = awvalid_q;
    assign o_wdata      = wdata_q;
    assign o_wstrb      = wstrb_q;
    assign o_wvalid     = wvalid_q;
    assign o_bready     = (state_q == WR_RESP);

endmodule

// File: tb/tb_riscv_pu_mem_load_store_unit.sv
// Bench for riscv_pu_mem_load_store_unit: vector table driven through a responding AXI-Lite
// slave, results checked against a scoreboard, plus reset and zero-wait-state sequences.
module tb_riscv_pu_mem_load_store_unit;

    logic        clk = 1'b0;
    logic        i_rst, i_valid, o_ready, i_read, i_write;
    logic [2:0]  i_width;
    logic [63:0] i_alu_data, i_rs2_data, o_data, i_rdata, o_wdata;
    logic        o_valid, o_misaligned, o_bus_error;
    logic [31:0] o_araddr, o_awaddr;
    logic        o_arvalid, i_arready, i_rvalid, o_rready, o_awvalid, i_awready;
    logic [1:0]  i_rresp, i_bresp;
    logic [7:0]  o_wstrb;
    logic        o_wvalid, i_wready, i_bvalid, o_bready;

    always #5 clk = ~clk;

    riscv_pu_mem_load_store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_read(i_read), .i_write(i_write), .i_width(i_width),
        .i_alu_data(i_alu_data), .i_rs2_data(i_rs2_data),
        .o_valid(o_valid), .o_data(o_data), .o_misaligned(o_misaligned), .o_bus_error(o_bus_error),
        .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
        .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
    );

    typedef struct {
        logic        rd, wr;
        logic [2:0]  width;
        logic [63:0] alu, rs2, rdata;
        logic [1:0]  resp;
        int          ar_d, r_d, aw_d, w_d, b_d;
        int          kind;      // 0 = no bus cycle, 1 = read, 2 = write
        logic [31:0] exp_addr;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wdata, exp_data;
        logic        exp_mis, exp_berr;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        mis, berr;
    } exp_t;

    localparam int NV = 20;
    vec_t vecs[NV];
    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Scoreboard side: every o_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (o_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_o_valid: got o_valid=1, expected no pending result");
            end else begin
                mon_e = sb.pop_front();
                check("sb_data", o_data, mon_e.data);
                check("sb_misaligned", {63'b0, o_misaligned}, {63'b0, mon_e.mis});
                check("sb_bus_error", {63'b0, o_bus_error}, {63'b0, mon_e.berr});
            end
        end
    end

    task automatic do_txn(input vec_t v, input bit early, input int idx);
        int   cyc, ar_n, r_n, aw_n, w_n, b_n;
        bit   got, saw_ar, saw_aw, saw_w, busy_err, hs_err;
        logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
        exp_t e;
        {cyc, ar_n, r_n, aw_n, w_n, b_n} = '0;
        {got, saw_ar, saw_aw, saw_w, busy_err, hs_err} = '0;
        {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr} = '0;
        for (int k = 0; k < 50 && !o_ready; k++) @(negedge clk);
        i_valid = 1'b1; i_read = v.rd; i_write = v.wr; i_width = v.width;
        i_alu_data = v.alu; i_rs2_data = v.rs2;
        i_rdata = v.rdata; i_rresp = v.resp; i_bresp = v.resp;
        if (early) begin
            i_arready = 1'b1; i_rvalid = 1'b1; i_awready = 1'b1; i_wready = 1'b1; i_bvalid = 1'b1;
        end
        e.data = v.exp_data; e.mis = v.exp_mis; e.berr = v.exp_berr;
        sb.push_back(e);
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            i_valid = 1'b0;
            if (p_arv && !p_arr && !o_arvalid) hs_err = 1'b1;
            if (p_awv && (p_awr == o_awvalid)) hs_err = 1'b1;
            if (p_wv && (p_wr == o_wvalid)) hs_err = 1'b1;
            if (o_arvalid && !saw_ar) begin
                saw_ar = 1'b1;
                check($sformatf("v%0d_araddr", idx), {32'b0, o_araddr}, {32'b0, v.exp_addr});
            end
            if (o_awvalid && !saw_aw) begin
                saw_aw = 1'b1;
                check($sformatf("v%0d_awaddr", idx), {32'b0, o_awaddr}, {32'b0, v.exp_addr});
            end
            if (o_wvalid && !saw_w) begin
                saw_w = 1'b1;
                check($sformatf("v%0d_wdata", idx), o_wdata, v.exp_wdata);
                check($sformatf("v%0d_wstrb", idx), {56'b0, o_wstrb}, {56'b0, v.exp_strb});
            end
            if (o_valid) got = 1'b1;
            else if (o_ready) busy_err = 1'b1;
            if (!early) begin
                if (o_arvalid) begin ar_n++; i_arready = (ar_n > v.ar_d); end else i_arready = 1'b0;
                if (o_rready)  begin r_n++;  i_rvalid  = (r_n > v.r_d);   end else i_rvalid  = 1'b0;
                if (o_awvalid) begin aw_n++; i_awready = (aw_n > v.aw_d); end else i_awready = 1'b0;
                if (o_wvalid)  begin w_n++;  i_wready  = (w_n > v.w_d);   end else i_wready  = 1'b0;
                if (o_bready)  begin b_n++;  i_bvalid  = (b_n > v.b_d);   end else i_bvalid  = 1'b0;
            end
            p_arv = o_arvalid; p_arr = i_arready;
            p_awv = o_awvalid; p_awr = i_awready;
            p_wv  = o_wvalid;  p_wr  = i_wready;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL v%0d_timeout: got no o_valid in %0d cycles, expected one", idx, cyc);
            sb.delete();
        end
        check($sformatf("v%0d_ready_low_while_busy", idx), {63'b0, busy_err}, 64'd0);
        check($sformatf("v%0d_valid_handshake", idx), {63'b0, hs_err}, 64'd0);
        check($sformatf("v%0d_read_bus", idx), {63'b0, saw_ar}, {63'b0, v.kind == 1});
        check($sformatf("v%0d_write_bus", idx), {63'b0, saw_aw | saw_w}, {63'b0, v.kind == 2});
        if (early) check($sformatf("v%0d_min_latency", idx), 64'(cyc), 64'd3);
        if (v.kind == 0) check($sformatf("v%0d_latency", idx), 64'(cyc), 64'd1);
        i_arready = 1'b0; i_rvalid = 1'b0; i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_single_pulse", idx), {63'b0, o_valid}, 64'd0);
        check($sformatf("v%0d_ready_after", idx), {63'b0, o_ready}, 64'd1);
        check($sformatf("v%0d_data_hold", idx), o_data, v.exp_data);
        check($sformatf("v%0d_flag_hold", idx), {62'b0, o_misaligned, o_bus_error},
              {62'b0, v.exp_mis, v.exp_berr});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000 ns, expected earlier completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_read = 1'b0; i_write = 1'b0; i_width = 3'b0;
        i_alu_data = '0; i_rs2_data = '0; i_rdata = '0; i_rresp = 2'b0; i_bresp = 2'b0;
        i_arready = 1'b0; i_rvalid = 1'b0; i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {63'b0, o_ready}, 64'd1);
        check("rst_valid_flags", {61'b0, o_valid, o_misaligned, o_bus_error}, 64'd0);
        check("rst_data", o_data, 64'd0);
        check("rst_addrs", {o_araddr, o_awaddr}, 64'd0);
        check("rst_wdata_wstrb", o_wdata | {56'b0, o_wstrb}, 64'd0);
        check("rst_handshakes", {59'b0, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready}, 64'd0);
        i_rst = 1'b0;
        @(negedge clk);

        //             rd    wr    width   alu               rs2                     rdata                   resp  ar r aw w b kind addr           strb   wdata                   data                    mis   berr
        vecs[0]  = '{1'b0, 1'b0, 3'b000, 64'h1234,         64'h0,                  64'h0,                  2'd0, 0, 0, 0, 0, 0, 0, 32'h0,     8'h00, 64'h0,                  64'h1234,               1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b100, 64'h1003,         64'h0,                  64'h0000_0000_8000_0000, 2'd0, 1, 2, 0, 0, 0, 1, 32'h1000,  8'h00, 64'h0,                  64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b000, 64'h1003,         64'h0,                  64'h0000_0000_8000_0000, 2'd0, 0, 0, 0, 0, 0, 1, 32'h1000,  8'h00, 64'h0,                  64'h80,                 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'b010, 64'h2004,         64'hDEAD_BEEF,          64'h0,                  2'd0, 0, 0, 1, 1, 1, 2, 32'h2000,  8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0,                  1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'b010, 64'h2000,         64'h0000_0000_CAFE_F00D, 64'h0,                 2'd0, 0, 0, 0, 3, 2, 2, 32'h2000,  8'h0F, 64'h0000_0000_CAFE_F00D, 64'h0,                  1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'b011, 64'h3004,         64'h0,                  64'h0,                  2'd0, 0, 0, 0, 0, 0, 0, 32'h0,     8'h00, 64'h0,                  64'h0,                  1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'b101, 64'h4006,         64'h0,                  64'h8765_4321_0000_0000, 2'd0, 2, 0, 0, 0, 0, 1, 32'h4000,  8'h00, 64'h0,                  64'hFFFF_FFFF_FFFF_8765, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'b010, 64'h5004,         64'h0,                  64'hF00D_CAFE_1111_2222, 2'd0, 0, 1, 0, 0, 0, 1, 32'h5000,  8'h00, 64'h0,                  64'h0000_0000_F00D_CAFE, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'b110, 64'h5004,         64'h0,                  64'hF00D_CAFE_1111_2222, 2'd0, 0, 0, 0, 0, 0, 1, 32'h5000,  8'h00, 64'h0,                  64'hFFFF_FFFF_F00D_CAFE, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 3'b011, 64'h6008,         64'h0,                  64'h0123_4567_89AB_CDEF, 2'd0, 1, 1, 0, 0, 0, 1, 32'h6008,  8'h00, 64'h0,                  64'h0123_4567_89AB_CDEF, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'b000, 64'h7001,         64'h0,                  64'h0000_0000_0000_5A00, 2'd2, 0, 0, 0, 0, 0, 1, 32'h7000,  8'h00, 64'h0,                  64'h5A,                 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 3'b000, 64'h8005,         64'hFFFF_FFFF_FFFF_FFAB, 64'h0,                 2'd2, 0, 0, 2, 0, 1, 2, 32'h8000,  8'h20, 64'h0000_AB00_0000_0000, 64'h0,                  1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 3'b001, 64'h9002,         64'h1234_5678_9ABC_DEF0, 64'h0,                 2'd0, 0, 0, 0, 0, 0, 2, 32'h9000,  8'h0C, 64'h0000_0000_DEF0_0000, 64'h0,                  1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 3'b001, 64'hA001,         64'h55,                 64'h0,                  2'd0, 0, 0, 0, 0, 0, 0, 32'h0,     8'h00, 64'h0,                  64'h0,                  1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 3'b010, 64'hA002,         64'h0,                  64'h0,                  2'd0, 0, 0, 0, 0, 0, 0, 32'h0,     8'h00, 64'h0,                  64'h0,                  1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 3'b010, 64'hB000,         64'h99,                 64'hAAAA_AAAA_7FFF_FFFF, 2'd0, 0, 0, 0, 0, 0, 1, 32'hB000,  8'h00, 64'h0,                  64'h0000_0000_7FFF_FFFF, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 3'b011, 64'hC000,         64'h1122_3344_5566_7788, 64'h0,                 2'd0, 1, 0, 1, 1, 0, 2, 32'hC000,  8'hFF, 64'h1122_3344_5566_7788, 64'h0,                  1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 3'b111, 64'hFFFF_FFFF_0000_0001, 64'h0,           64'h0,                  2'd0, 0, 0, 0, 0, 0, 0, 32'h0,     8'h00, 64'h0,                  64'hFFFF_FFFF_0000_0001, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 3'b100, 64'hD007,         64'h0,                  64'h7F00_0000_0000_0000, 2'd0, 0, 0, 0, 0, 0, 1, 32'hD000,  8'h00, 64'h0,                  64'h7F,                 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 3'b001, 64'hE000,         64'h0,                  64'h0000_0000_0000_FFFE, 2'd0, 0, 3, 0, 0, 0, 1, 32'hE000,  8'h00, 64'h0,                  64'hFFFE,               1'b0, 1'b0};

        for (int i = 0; i < NV; i++) do_txn(vecs[i], 1'b0, i);

        // Slave ready/valid already high when the unit raises its valids.
        do_txn(vecs[2], 1'b1, 100);
        do_txn(vecs[3], 1'b1, 101);

        // Reset while waiting for read data: abort to IDLE with no result.
        i_valid = 1'b1; i_read = 1'b1; i_write = 1'b0; i_width = 3'b000; i_alu_data = 64'h1000;
        @(negedge clk);
        i_valid = 1'b0;
        i_arready = 1'b1;
        @(negedge clk);
        i_arready = 1'b0;
        check("abort_in_rd_data", {63'b0, o_rready}, 64'd1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("abort_ready", {63'b0, o_ready}, 64'd1);
        check("abort_rready", {63'b0, o_rready}, 64'd0);
        check("abort_valid", {63'b0, o_valid}, 64'd0);
        repeat (2) @(negedge clk);
        check("abort_no_late_valid", {63'b0, o_valid}, 64'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
